par_ar_readarbiter: RTL and testbench
=====================================

# par_AR_ReadArbiter

Round-robin read-channel arbiter and sequencer for the AXI interconnect. It picks one of `MasterCount` masters requesting on AR and drives the `state` and one-hot `ARsel_Master` that steer the AR master-to-slave multiplexer. It holds the grant through the address phase and the full read-data burst, routes AR/R handshakes to the granted master, and checks burst length against RLAST.

## Interface
- `MasterCount`, default 2: number of masters; legal range 1 to 16.
- `AXI_LEN_BITS`, default from `AXI_define.svh` (4): burst-length field width.
- `ACLK`  in  1  clock; all state updates on the rising edge.
- `ARESET`  in  1  asynchronous, active-high reset.
- `ARVALID_MS`  in  [MasterCount]  per-master AR valid.
- `ARLEN_MS`  in  [MasterCount][AXI_LEN_BITS]  per-master ARLEN.
- `ARREADY`  in  1  ARREADY from the addressed slave.
- `RVALID`  in  1  RVALID from the slave.
- `RLAST`  in  1  RLAST from the slave.
- `RREADY_MS`  in  [MasterCount]  per-master RREADY.
- `state`  out  2  `READSTATE_IDLE`=0, `READSTATE_ARTRANS`=1, `READSTATE_RTRANS`=2; 3 is unused.
- `ARsel_Master`  out  [MasterCount]  one-hot grant, or all-zero.
- `ARREADY_MS`  out  [MasterCount]  ARREADY routed to the granted master.
- `RVALID_MS`  out  [MasterCount]  RVALID routed to the granted master.
- `RREADY`  out  1  RREADY of the granted master, sent to the slave.
- `len_err`  out  1  one-cycle pulse on a burst-length mismatch.
- `busy`  out  1  high when `state` is not IDLE.

## Operation
- Registers:
  - `state_q`
  - `sel_q` [MasterCount]
  - `rr_ptr` [clog2(MasterCount)]
  - `beat_cnt` [AXI_LEN_BITS]
  - `len_err`
- Reset: all registers cleared.
- Resulting output values in reset:
  - `state`=IDLE, `busy`=0, `len_err`=0.
  - `ARsel_Master`, `ARREADY_MS`, `RVALID_MS` and `RREADY` are 0.
  - Exception: `ARsel_Master` and `ARREADY_MS` may be nonzero if `ARVALID_MS` is already asserted.
- IDLE:
  - `ARsel_Master` is combinational: the first requester found when searching from index `rr_ptr` upward, wrapping at MasterCount-1→0.
  - With no requester it is all-zero.
  - `ARREADY_MS[g] = ARREADY` for the picked master g.
- ARTRANS and RTRANS: `ARsel_Master = sel_q`, registered and stable.
- AR handshake: `ARVALID_MS[g] & ARREADY` for the selected master g, in IDLE or ARTRANS. On the handshake:
  - `beat_cnt <= ARLEN_MS[g]`
  - `rr_ptr <= (g+1) mod MasterCount`
  - `state_q <= RTRANS`
- Transitions:
  - IDLE, request present, no handshake: `sel_q <=` pick, go to ARTRANS.
  - IDLE, handshake in the same cycle: `sel_q <=` pick, go directly to RTRANS (zero-wait).
  - ARTRANS: hold until the handshake; grant never changes while waiting.
  - RTRANS, R handshake (`RVALID & RREADY`) with `RLAST`: go to IDLE.
  - RTRANS, R handshake without `RLAST`: `beat_cnt <= beat_cnt - 1`; stay in RTRANS.
- Routing:
  - `ARREADY_MS` is 0 in RTRANS.
  - `RVALID_MS[i] = RVALID & sel_q[i]` only in RTRANS, else 0.
  - `RREADY = |(RREADY_MS & sel_q)` only in RTRANS, else 0.
- Length check: `len_err` pulses 1 for one cycle after an R handshake where either
  - `RLAST=1` and `beat_cnt != 0` (early last), or
  - `RLAST=0` and `beat_cnt == 0` (overrun). `beat_cnt` stays 0 (no underflow), and the arbiter stays in RTRANS until `RLAST`.
- Requests from non-granted masters are ignored until return to IDLE; no preemption.
- `state=3` in `state_q` (unreachable) recovers to IDLE on the next clock.

## Timing
- Arbitration latency is 0 cycles: the grant is visible in the cycle a request appears in IDLE.
- Minimum single-beat transaction:
  - AR handshake in IDLE at cycle 0.
  - R handshake with `RLAST` in RTRANS at cycle 1.
  - IDLE at cycle 2.
- After a burst completes, the earliest new grant is the cycle immediately following.
- A new IDLE pick uses the updated `rr_ptr`.
- `len_err` is registered and appears the cycle after the offending beat.
- ARESET mid-transaction: all outputs reach reset values asynchronously; the in-flight burst is abandoned and its pointer history is lost.

## Test plan
- Reset, then M1 ARVALID with ARLEN=0 and ARREADY=1 in the same cycle:
  - `ARsel_Master`=2'b10 combinationally, next state RTRANS.
  - One beat with RLAST → IDLE; `len_err`=0.
- M0 and M1 request continuously with `rr_ptr`=0 and ARLEN=0: grants go M0, M1, M0, M1; each `ARsel_Master` is stable through its RTRANS.
- ARREADY held low 3 cycles:
  - state stays ARTRANS with `sel_q` fixed.
  - Dropping the competing request has no effect on the grant.
  - Handshake on cycle 4 → RTRANS.
- ARLEN=3 burst with RREADY_MS toggling: `beat_cnt` goes 3,2,1,0; IDLE after the 4th beat carrying RLAST; `len_err`=0.
- ARLEN=3 with RLAST on beat 2 → `len_err` pulse; IDLE. Separately, ARLEN=1 with RLAST on beat 4 → two `len_err` pulses (beats 3 and 4); IDLE after beat 4.
- ARESET asserted during RTRANS:
  - state=IDLE, `RREADY`=0, `RVALID_MS`=0 immediately.
  - `rr_ptr`=0, so M0 wins the next simultaneous request.

Source files
------------

// File: rtl/par_ar_readarbiter.sv
// rtl/par_ar_readarbiter.sv - round-robin AR arbiter that holds its grant through the read burst
// Steers the AR mux, routes AR/R handshakes to the granted master and checks burst length.
module par_ar_readarbiter #(
  parameter int MasterCount  = 2,
  parameter int AXI_LEN_BITS = 4
) (
  input  logic                                      ACLK,
  input  logic                                      ARESET,
  input  logic [MasterCount-1:0]                    ARVALID_MS,
  input  logic [MasterCount-1:0][AXI_LEN_BITS-1:0]  ARLEN_MS,
  input  logic                                      ARREADY,
  input  logic                                      RVALID,
  input  logic                                      RLAST,
  input  logic [MasterCount-1:0]                    RREADY_MS,
  output logic [1:0]                                state,
  output logic [MasterCount-1:0]                    ARsel_Master,
  output logic [MasterCount-1:0]                    ARREADY_MS,
  output logic [MasterCount-1:0]                    RVALID_MS,
  output logic                                      RREADY,
  output logic                                      len_err,
  output logic                                      busy
);

  localparam int PW = (MasterCount > 1) ? $clog2(MasterCount) : 1;

  typedef enum logic [1:0] {
    READSTATE_IDLE    = 2'd0,
    READSTATE_ARTRANS = 2'd1,
    READSTATE_RTRANS  = 2'd2,
    READSTATE_UNUSED  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [MasterCount-1:0]  sel_q, sel_d;
  logic [PW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [AXI_LEN_BITS-1:0] beat_cnt_q, beat_cnt_d;
  logic                    len_err_q, len_err_d;

  logic [MasterCount-1:0]  pick;
  logic [PW-1:0]           pick_idx;
  logic                    pick_vld;
  logic [PW-1:0]           sel_idx;
  logic [PW-1:0]           g_idx;
  logic                    ar_hs;
  logic                    r_hs;
  int                      cand;

  // Search upward from rr_ptr, wrapping, so the last winner has lowest priority.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    pick_vld = 1'b0;
    cand     = 0;
    for (int i = 0; i < MasterCount; i++) begin
      cand = (int'(rr_ptr_q) + i) % MasterCount;
      if (!pick_vld && ARVALID_MS[cand]) begin
        pick_vld     = 1'b1;
        pick[cand]   = 1'b1;
        pick_idx     = PW'(cand);
      end
    end
  end

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < MasterCount; i++) begin
      if (sel_q[i]) sel_idx = PW'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    rr_ptr_d     = rr_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    len_err_d    = 1'b0;
    ARsel_Master = '0;
    ARREADY_MS   = '0;
    RVALID_MS    = '0;
    RREADY       = 1'b0;
    ar_hs        = 1'b0;
    r_hs         = 1'b0;
    g_idx        = sel_idx;

    case (state_q)
      READSTATE_IDLE: begin
        ARsel_Master = pick;
        g_idx        = pick_idx;
        ARREADY_MS   = pick & {MasterCount{ARREADY}};
        ar_hs        = (|(pick & ARVALID_MS)) & ARREADY;
        if (pick_vld) begin
          sel_d   = pick;
          state_d = ar_hs ? READSTATE_RTRANS : READSTATE_ARTRANS;
        end
      end
      READSTATE_ARTRANS: begin
        ARsel_Master = sel_q;
        ARREADY_MS   = sel_q & {MasterCount{ARREADY}};
        ar_hs        = (|(sel_q & ARVALID_MS)) & ARREADY;
        if (ar_hs) state_d = READSTATE_RTRANS;
      end
      READSTATE_RTRANS: begin
        ARsel_Master = sel_q;
        RVALID_MS    = sel_q & {MasterCount{RVALID}};
        RREADY       = |(RREADY_MS & sel_q);
        r_hs         = RVALID & RREADY;
        if (r_hs) begin
          len_err_d = RLAST ? (beat_cnt_q != '0) : (beat_cnt_q == '0);
          if (RLAST) begin
            state_d = READSTATE_IDLE;
          end else if (beat_cnt_q != '0) begin
            beat_cnt_d = beat_cnt_q - 1'b1;
          end
        end
      end
      default: state_d = READSTATE_IDLE;
    endcase

    if (ar_hs) begin
      beat_cnt_d = ARLEN_MS[g_idx];
      rr_ptr_d   = (g_idx == PW'(MasterCount - 1)) ? '0 : g_idx + PW'(1);
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q    <= READSTATE_IDLE;
      sel_q      <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      len_err_q  <= len_err_d;
    end
  end

  assign state   = state_q;
  assign len_err = len_err_q;
  assign busy    = (state_q != READSTATE_IDLE);

endmodule

// File: tb/tb_par_ar_readarbiter.sv
// tb/tb_par_ar_readarbiter.sv - scenario bench for par_ar_readarbiter
// Expected grants are queued when a request is driven and popped when the AR handshake is seen.
module tb_par_ar_readarbiter;

  logic            ACLK = 1'b0;
  logic            ARESET = 1'b1;
  logic [1:0]      ARVALID_MS = '0;
  logic [1:0][3:0] ARLEN_MS = '0;
  logic            ARREADY = 1'b0;
  logic            RVALID = 1'b0;
  logic            RLAST = 1'b0;
  logic [1:0]      RREADY_MS = '0;
  logic [1:0]      state;
  logic [1:0]      ARsel_Master;
  logic [1:0]      ARREADY_MS;
  logic [1:0]      RVALID_MS;
  logic            RREADY;
  logic            len_err;
  logic            busy;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_g;

  par_ar_readarbiter #(.MasterCount(2), .AXI_LEN_BITS(4)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .ARVALID_MS(ARVALID_MS), .ARLEN_MS(ARLEN_MS),
    .ARREADY(ARREADY), .RVALID(RVALID), .RLAST(RLAST), .RREADY_MS(RREADY_MS),
    .state(state), .ARsel_Master(ARsel_Master), .ARREADY_MS(ARREADY_MS),
    .RVALID_MS(RVALID_MS), .RREADY(RREADY), .len_err(len_err), .busy(busy)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clear_inputs();
    ARVALID_MS = '0; ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RREADY_MS = '0;
  endtask

  task automatic test_reset();
    #2;
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d expected 0", state); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_tests++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL rst_len_err: got %b expected 0", len_err); end
    n_tests++; if (ARsel_Master !== 2'b00) begin n_fail++; $display("FAIL rst_arsel: got %b expected 00", ARsel_Master); end
    n_tests++; if ({ARREADY_MS, RVALID_MS, RREADY} !== 5'b0) begin n_fail++; $display("FAIL rst_routes: got %b expected 00000", {ARREADY_MS, RVALID_MS, RREADY}); end
    @(posedge ACLK); #1;
    ARESET = 1'b0;
  endtask

  task automatic test_zero_wait();
    ARVALID_MS = 2'b10; ARLEN_MS[1] = 4'd0; ARREADY = 1'b1;
    exp_q.push_back(2'b10);
    #2;
    exp_g = exp_q.pop_front();
    n_tests++; if (ARsel_Master !== exp_g) begin n_fail++; $display("FAIL zw_grant: got %b expected %b", ARsel_Master, exp_g); end
    n_tests++; if (ARREADY_MS !== 2'b10) begin n_fail++; $display("FAIL zw_arready: got %b expected 10", ARREADY_MS); end
    tick();
    clear_inputs();
    RVALID = 1'b1; RLAST = 1'b1; RREADY_MS = 2'b10;
    #2;
    n_tests++; if (state !== 2'd2) begin n_fail++; $display("FAIL zw_rtrans: got %0d expected 2", state); end
    n_tests++; if (RVALID_MS !== 2'b10) begin n_fail++; $display("FAIL zw_rvalid: got %b expected 10", RVALID_MS); end
    n_tests++; if (RREADY !== 1'b1) begin n_fail++; $display("FAIL zw_rready: got %b expected 1", RREADY); end
    tick();
    clear_inputs();
    #2;
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL zw_idle: got %0d expected 0", state); end
    n_tests++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL zw_len_err: got %b expected 0", len_err); end
    tick();
  endtask

  task automatic test_round_robin();
    ARVALID_MS = 2'b11; ARLEN_MS = '0; ARREADY = 1'b1;
    RVALID = 1'b1; RLAST = 1'b1; RREADY_MS = 2'b11;
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    exp_g = 2'b00;
    for (int c = 0; c < 8; c++) begin
      #2;
      if (c % 2 == 0) begin
        exp_g = exp_q.pop_front();
        n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL rr_idle%0d: got %0d expected 0", c, state); end
        n_tests++; if (ARsel_Master !== exp_g) begin n_fail++; $display("FAIL rr_grant%0d: got %b expected %b", c, ARsel_Master, exp_g); end
      end else begin
        n_tests++; if (state !== 2'd2) begin n_fail++; $display("FAIL rr_rtrans%0d: got %0d expected 2", c, state); end
        n_tests++; if (ARsel_Master !== exp_g) begin n_fail++; $display("FAIL rr_stable%0d: got %b expected %b", c, ARsel_Master, exp_g); end
        n_tests++; if (RVALID_MS !== exp_g) begin n_fail++; $display("FAIL rr_rvalid%0d: got %b expected %b", c, RVALID_MS, exp_g); end
      end
      tick();
    end
    clear_inputs();
    #2;
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL rr_end: got %0d expected 0", state); end
    tick();
  endtask

  task automatic test_artrans_hold();
    ARVALID_MS = 2'b11; ARLEN_MS = '0; ARREADY = 1'b0;
    exp_q.push_back(2'b01);
    #2;
    exp_g = exp_q.pop_front();
    n_tests++; if (ARsel_Master !== exp_g) begin n_fail++; $display("FAIL ah_grant: got %b expected %b", ARsel_Master, exp_g); end
    tick();
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) ARVALID_MS = 2'b01;
      #2;
      n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL ah_state%0d: got %0d expected 1", c, state); end
      n_tests++; if (ARsel_Master !== exp_g) begin n_fail++; $display("FAIL ah_sel%0d: got %b expected %b", c, ARsel_Master, exp_g); end
      tick();
    end
    ARREADY = 1'b1;
    #2;
    n_tests++; if (ARREADY_MS !== 2'b01) begin n_fail++; $display("FAIL ah_arready: got %b expected 01", ARREADY_MS); end
    tick();
    clear_inputs();
    RVALID = 1'b1; RLAST = 1'b1; RREADY_MS = 2'b01;
    #2;
    n_tests++; if (state !== 2'd2) begin n_fail++; $display("FAIL ah_rtrans: got %0d expected 2", state); end
    tick();
    clear_inputs();
    #2;
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL ah_idle: got %0d expected 0", state); end
    tick();
  endtask

  task automatic test_burst();
    int beats;
    ARVALID_MS = 2'b10; ARLEN_MS[1] = 4'd3; ARREADY = 1'b1;
    exp_q.push_back(2'b10);
    #2;
    exp_g = exp_q.pop_front();
    n_tests++; if (ARsel_Master !== exp_g) begin n_fail++; $display("FAIL bu_grant: got %b expected %b", ARsel_Master, exp_g); end
    tick();
    clear_inputs();
    beats = 0;
    for (int c = 0; c < 12 && beats < 4; c++) begin
      RVALID = 1'b1;
      RREADY_MS = (c % 2 == 0) ? 2'b10 : 2'b00;
      RLAST = (beats == 3);
      #2;
      n_tests++; if (RREADY !== (c % 2 == 0)) begin n_fail++; $display("FAIL bu_rready%0d: got %b expected %b", c, RREADY, (c % 2 == 0)); end
      if (c % 2 == 0) begin
        n_tests++; if (dut.beat_cnt_q !== 4'(3 - beats)) begin n_fail++; $display("FAIL bu_cnt%0d: got %0d expected %0d", beats, dut.beat_cnt_q, 3 - beats); end
        beats++;
      end else begin
        n_tests++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL bu_len_err%0d: got %b expected 0", c, len_err); end
      end
      tick();
    end
    clear_inputs();
    #2;
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL bu_idle: got %0d expected 0", state); end
    n_tests++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL bu_last_err: got %b expected 0", len_err); end
    tick();
  endtask

  task automatic test_len_err_early();
    ARVALID_MS = 2'b01; ARLEN_MS[0] = 4'd3; ARREADY = 1'b1;
    exp_q.push_back(2'b01);
    #2;
    exp_g = exp_q.pop_front();
    n_tests++; if (ARsel_Master !== exp_g) begin n_fail++; $display("FAIL ee_grant: got %b expected %b", ARsel_Master, exp_g); end
    tick();
    clear_inputs();
    RVALID = 1'b1; RREADY_MS = 2'b01;
    #2;
    tick();
    RLAST = 1'b1;
    #2;
    n_tests++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL ee_beat1: got %b expected 0", len_err); end
    tick();
    clear_inputs();
    #2;
    n_tests++; if (len_err !== 1'b1) begin n_fail++; $display("FAIL ee_pulse: got %b expected 1", len_err); end
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL ee_idle: got %0d expected 0", state); end
    tick();
    #2;
    n_tests++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL ee_clear: got %b expected 0", len_err); end
    tick();
  endtask

  task automatic test_len_err_overrun();
    ARVALID_MS = 2'b10; ARLEN_MS[1] = 4'd1; ARREADY = 1'b1;
    exp_q.push_back(2'b10);
    #2;
    exp_g = exp_q.pop_front();
    n_tests++; if (ARsel_Master !== exp_g) begin n_fail++; $display("FAIL ov_grant: got %b expected %b", ARsel_Master, exp_g); end
    tick();
    clear_inputs();
    for (int b = 1; b <= 4; b++) begin
      RVALID = 1'b1; RREADY_MS = 2'b10; RLAST = (b == 4);
      #2;
      n_tests++; if (len_err !== (b >= 3)) begin n_fail++; $display("FAIL ov_err_beat%0d: got %b expected %b", b, len_err, (b >= 3)); end
      n_tests++; if (state !== 2'd2) begin n_fail++; $display("FAIL ov_state%0d: got %0d expected 2", b, state); end
      if (b >= 2) begin
        n_tests++; if (dut.beat_cnt_q !== 4'd0) begin n_fail++; $display("FAIL ov_cnt%0d: got %0d expected 0", b, dut.beat_cnt_q); end
      end
      tick();
    end
    clear_inputs();
    #2;
    n_tests++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL ov_after: got %b expected 0", len_err); end
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL ov_idle: got %0d expected 0", state); end
    tick();
  endtask

  task automatic test_reset_mid();
    ARVALID_MS = 2'b01; ARLEN_MS = '0; ARREADY = 1'b1;
    exp_q.push_back(2'b01);
    #2;
    exp_g = exp_q.pop_front();
    n_tests++; if (ARsel_Master !== exp_g) begin n_fail++; $display("FAIL rm_grant0: got %b expected %b", ARsel_Master, exp_g); end
    tick();
    clear_inputs();
    RVALID = 1'b1; RLAST = 1'b1; RREADY_MS = 2'b01;
    #2;
    tick();
    clear_inputs();
    // rr_ptr now points at M1, so M1 wins the tie before the reset.
    ARVALID_MS = 2'b11; ARREADY = 1'b1;
    exp_q.push_back(2'b10);
    #2;
    exp_g = exp_q.pop_front();
    n_tests++; if (ARsel_Master !== exp_g) begin n_fail++; $display("FAIL rm_grant1: got %b expected %b", ARsel_Master, exp_g); end
    tick();
    ARREADY = 1'b0; RVALID = 1'b1; RLAST = 1'b0; RREADY_MS = 2'b11;
    #2;
    n_tests++; if (RREADY !== 1'b1) begin n_fail++; $display("FAIL rm_rready_pre: got %b expected 1", RREADY); end
    ARESET = 1'b1;
    #1;
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL rm_state: got %0d expected 0", state); end
    n_tests++; if (RREADY !== 1'b0) begin n_fail++; $display("FAIL rm_rready: got %b expected 0", RREADY); end
    n_tests++; if (RVALID_MS !== 2'b00) begin n_fail++; $display("FAIL rm_rvalid: got %b expected 00", RVALID_MS); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b expected 0", busy); end
    RVALID = 1'b0; ARREADY = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    exp_q.push_back(2'b01);
    #2;
    exp_g = exp_q.pop_front();
    n_tests++; if (ARsel_Master !== exp_g) begin n_fail++; $display("FAIL rm_after: got %b expected %b", ARsel_Master, exp_g); end
    tick();
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_round_robin();
    test_artrans_hold();
    test_burst();
    test_len_err_early();
    test_len_err_overrun();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
